// File: rtl/vc_arbiter_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : vc_arbiter_ctrl_if
//  Brief    : Bundle between the VC arbiter controller and its VC/D FIFOs.
//  Revision : 1.0
// ============================================================================
interface vc_arbiter_ctrl_if #(
  parameter int DATA_SIZE = 6
);
  logic                 init;
  logic [DATA_SIZE-1:0] umbral_af_in;
  logic [DATA_SIZE-1:0] umbral_ae_in;
  logic                 fifo_empty_vc0;
  logic                 fifo_empty_vc1;
  logic                 fifo_error_vc0;
  logic                 fifo_error_vc1;
  logic [DATA_SIZE-1:0] data_vc0;
  logic [DATA_SIZE-1:0] data_vc1;
  logic                 pause_d0;
  logic                 pause_d1;
  logic                 pop_vc0;
  logic                 pop_vc1;
  logic                 push_d0;
  logic                 push_d1;
  logic [DATA_SIZE-1:0] data_out;
  logic [DATA_SIZE-1:0] afVC_o;
  logic [DATA_SIZE-1:0] aeVC_o;
  logic [2:0]           state;
  logic                 idle;
  logic                 error_out;

  modport master (
    input  init, umbral_af_in, umbral_ae_in,
    input  fifo_empty_vc0, fifo_empty_vc1, fifo_error_vc0, fifo_error_vc1,
    input  data_vc0, data_vc1, pause_d0, pause_d1,
    output pop_vc0, pop_vc1, push_d0, push_d1, data_out,
    output afVC_o, aeVC_o, state, idle, error_out
  );

  modport slave (
    output init, umbral_af_in, umbral_ae_in,
    output fifo_empty_vc0, fifo_empty_vc1, fifo_error_vc0, fifo_error_vc1,
    output data_vc0, data_vc1, pause_d0, pause_d1,
    input  pop_vc0, pop_vc1, push_d0, push_d1, data_out,
    input  afVC_o, aeVC_o, state, idle, error_out
  );
endinterface
`default_nettype wire

// File: rtl/vc_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : vc_arbiter_ctrl
//  Brief    : Threshold init FSM plus VC0/VC1 pop arbiter with anti-starvation
//             and destination routing of popped words to D0/D1.
//  Revision : 1.0
// ============================================================================
module vc_arbiter_ctrl #(
  parameter int DATA_SIZE    = 6,
  parameter int DEST_BIT     = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  wire logic         clk,
  input  wire logic         reset_L,
  vc_arbiter_ctrl_if.master ctrl_if
);

  localparam logic [2:0] c_ST_RESET  = 3'd0;
  localparam logic [2:0] c_ST_INIT   = 3'd1;
  localparam logic [2:0] c_ST_IDLE   = 3'd2;
  localparam logic [2:0] c_ST_ACTIVE = 3'd3;
  localparam logic [2:0] c_ST_ERROR  = 3'd4;
  localparam logic [2:0] c_STARVE_MAX = 3'(STARVE_LIMIT);

  logic [2:0]           state_q, state_d;
  logic [2:0]           starve_q, starve_d;
  logic                 inflight_q;
  logic                 src_vc1_q;
  logic                 push_d0_q, push_d1_q;
  logic [DATA_SIZE-1:0] data_out_q, af_q, ae_q;
  logic                 w_pop_vc0, w_pop_vc1;
  logic                 w_any_err;
  logic [DATA_SIZE-1:0] w_word;

  assign w_any_err = ctrl_if.fifo_error_vc0 | ctrl_if.fifo_error_vc1;
  assign w_word    = src_vc1_q ? ctrl_if.data_vc1 : ctrl_if.data_vc0;

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) state_q <= c_ST_RESET;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == c_ST_RESET) begin
      state_d = c_ST_INIT;
    end else if (ctrl_if.init) begin
      state_d = c_ST_INIT;
    end else if (w_any_err) begin
      state_d = c_ST_ERROR;
    end else begin
      case (state_q)
        c_ST_INIT:   state_d = c_ST_IDLE;
        c_ST_IDLE:   if (!ctrl_if.fifo_empty_vc0 || !ctrl_if.fifo_empty_vc1)
                       state_d = c_ST_ACTIVE;
        // A word popped last cycle keeps us ACTIVE until it has been pushed.
        c_ST_ACTIVE: if (ctrl_if.fifo_empty_vc0 && ctrl_if.fifo_empty_vc1 && !inflight_q)
                       state_d = c_ST_IDLE;
        c_ST_ERROR:  state_d = c_ST_ERROR;
        default:     state_d = c_ST_RESET;
      endcase
    end
  end

  // Either pause blocks popping: the destination is unknown until the word arrives.
  always_comb begin
    w_pop_vc0 = 1'b0;
    w_pop_vc1 = 1'b0;
    if (state_q == c_ST_ACTIVE && !ctrl_if.pause_d0 && !ctrl_if.pause_d1) begin
      if (!ctrl_if.fifo_empty_vc1 && (ctrl_if.fifo_empty_vc0 || starve_q == c_STARVE_MAX))
        w_pop_vc1 = 1'b1;
      else if (!ctrl_if.fifo_empty_vc0)
        w_pop_vc0 = 1'b1;
    end
  end

  always_comb begin
    starve_d = starve_q;
    if (ctrl_if.fifo_empty_vc1 || w_pop_vc1)
      starve_d = 3'd0;
    else if (w_pop_vc0 && starve_q != c_STARVE_MAX)
      starve_d = starve_q + 3'd1;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      starve_q   <= 3'd0;
      inflight_q <= 1'b0;
      src_vc1_q  <= 1'b0;
      push_d0_q  <= 1'b0;
      push_d1_q  <= 1'b0;
      data_out_q <= '0;
      af_q       <= '0;
      ae_q       <= '0;
    end else begin
      if (state_q == c_ST_INIT) begin
        af_q <= ctrl_if.umbral_af_in;
        ae_q <= ctrl_if.umbral_ae_in;
      end
      starve_q   <= starve_d;
      inflight_q <= w_pop_vc0 | w_pop_vc1;
      src_vc1_q  <= w_pop_vc1;
      // Push is independent of state so a word popped just before ERROR/INIT still lands.
      push_d0_q  <= inflight_q & ~w_word[DEST_BIT];
      push_d1_q  <= inflight_q &  w_word[DEST_BIT];
      if (inflight_q) data_out_q <= w_word;
    end
  end

  assign ctrl_if.pop_vc0   = w_pop_vc0;
  assign ctrl_if.pop_vc1   = w_pop_vc1;
  assign ctrl_if.push_d0   = push_d0_q;
  assign ctrl_if.push_d1   = push_d1_q;
  assign ctrl_if.data_out  = data_out_q;
  assign ctrl_if.afVC_o    = af_q;
  assign ctrl_if.aeVC_o    = ae_q;
  assign ctrl_if.state     = state_q;
  assign ctrl_if.idle      = (state_q == c_ST_IDLE);
  assign ctrl_if.error_out = (state_q == c_ST_ERROR);

endmodule
`default_nettype wire

// File: tb/tb_vc_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vc_arbiter_ctrl
//  Brief    : Randomized bench for vc_arbiter_ctrl against a queue-based model.
//  Revision : 1.0
// ============================================================================
module tb_vc_arbiter_ctrl;

  localparam int DATA_SIZE    = 6;
  localparam int DEST_BIT     = 4;
  localparam int STARVE_LIMIT = 4;
  localparam int ST_RESET = 0, ST_INIT = 1, ST_IDLE = 2, ST_ACTIVE = 3, ST_ERROR = 4;

  logic clk = 1'b0;
  logic reset_L;
  always #5 clk = ~clk;

  vc_arbiter_ctrl_if #(.DATA_SIZE(DATA_SIZE)) vif ();

  vc_arbiter_ctrl #(
    .DATA_SIZE   (DATA_SIZE),
    .DEST_BIT    (DEST_BIT),
    .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .clk    (clk),
    .reset_L(reset_L),
    .ctrl_if(vif.master)
  );

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: FIFO contents as queues, words in flight as a queue.
  logic [DATA_SIZE-1:0] q0[$], q1[$], flight[$];
  int                   m_state, m_streak;
  logic [DATA_SIZE-1:0] m_af, m_ae, m_dout;
  bit                   m_push0, m_push1;
  logic [DATA_SIZE-1:0] pend0, pend1;
  bit                   pend0_v, pend1_v;
  bit                   exp_pop0, exp_pop1;

  function automatic void model_reset();
    m_state  = ST_RESET;
    m_streak = 0;
    m_af     = '0;
    m_ae     = '0;
    m_dout   = '0;
    m_push0  = 1'b0;
    m_push1  = 1'b0;
    flight.delete();
  endfunction

  function automatic void model_step(input bit e0, input bit e1);
    bit                   had_flight;
    logic [DATA_SIZE-1:0] w;
    if (!reset_L) begin
      model_reset();
      return;
    end
    had_flight = (flight.size() != 0);
    m_push0 = 1'b0;
    m_push1 = 1'b0;
    if (had_flight) begin
      w       = flight.pop_front();
      m_dout  = w;
      m_push1 = w[DEST_BIT];
      m_push0 = !w[DEST_BIT];
    end
    if (exp_pop0) begin
      w = q0.pop_front(); flight.push_back(w); pend0 = w; pend0_v = 1'b1;
    end
    if (exp_pop1) begin
      w = q1.pop_front(); flight.push_back(w); pend1 = w; pend1_v = 1'b1;
    end
    if (e1 || exp_pop1)  m_streak = 0;
    else if (exp_pop0)   m_streak = (m_streak + 1 > STARVE_LIMIT) ? STARVE_LIMIT : m_streak + 1;
    if (m_state == ST_INIT) begin
      m_af = vif.umbral_af_in;
      m_ae = vif.umbral_ae_in;
    end
    if (m_state == ST_RESET || vif.init)                   m_state = ST_INIT;
    else if (vif.fifo_error_vc0 || vif.fifo_error_vc1)     m_state = ST_ERROR;
    else if (m_state == ST_INIT)                           m_state = ST_IDLE;
    else if (m_state == ST_IDLE && !(e0 && e1))            m_state = ST_ACTIVE;
    else if (m_state == ST_ACTIVE && e0 && e1 && !had_flight) m_state = ST_IDLE;
  endfunction

  task automatic check_regs();
    check_eq("state",    32'(vif.state),     32'(m_state));
    check_eq("idle",     32'(vif.idle),      32'(m_state == ST_IDLE));
    check_eq("error",    32'(vif.error_out), 32'(m_state == ST_ERROR));
    check_eq("push_d0",  32'(vif.push_d0),   32'(m_push0));
    check_eq("push_d1",  32'(vif.push_d1),   32'(m_push1));
    check_eq("data_out", 32'(vif.data_out),  32'(m_dout));
    check_eq("afVC",     32'(vif.afVC_o),    32'(m_af));
    check_eq("aeVC",     32'(vif.aeVC_o),    32'(m_ae));
  endtask

  // One clock cycle; inputs are set by the caller just after a falling edge.
  task automatic tick();
    bit e0, e1;
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    vif.fifo_empty_vc0 = e0;
    vif.fifo_empty_vc1 = e1;
    #1;
    exp_pop0 = 1'b0;
    exp_pop1 = 1'b0;
    if (m_state == ST_ACTIVE && !vif.pause_d0 && !vif.pause_d1) begin
      if (!e1 && (e0 || m_streak == STARVE_LIMIT)) exp_pop1 = 1'b1;
      else if (!e0)                                 exp_pop0 = 1'b1;
    end
    check_eq("pop_vc0", 32'(vif.pop_vc0), 32'(exp_pop0));
    check_eq("pop_vc1", 32'(vif.pop_vc1), 32'(exp_pop1));
    model_step(e0, e1);
    @(posedge clk);
    @(negedge clk);
    if (pend0_v) vif.data_vc0 = pend0;
    if (pend1_v) vif.data_vc1 = pend1;
    pend0_v = 1'b0;
    pend1_v = 1'b0;
    check_regs();
  endtask

  task automatic fill(input int n0, input int n1);
    for (int i = 0; i < n0; i++) q0.push_back(DATA_SIZE'($urandom));
    for (int i = 0; i < n1; i++) q1.push_back(DATA_SIZE'($urandom));
  endtask

  task automatic run_to_flight(input string tag);
    int k;
    for (k = 0; k < 20; k++) begin
      tick();
      if (flight.size() != 0) break;
    end
    check_eq(tag, 32'(k < 20), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    logic [DATA_SIZE-1:0] w15;
    reset_L = 1'b0;
    vif.init = 1'b0;
    vif.umbral_af_in = '0;
    vif.umbral_ae_in = '0;
    vif.fifo_error_vc0 = 1'b0;
    vif.fifo_error_vc1 = 1'b0;
    vif.data_vc0 = '0;
    vif.data_vc1 = '0;
    vif.pause_d0 = 1'b0;
    vif.pause_d1 = 1'b0;
    vif.fifo_empty_vc0 = 1'b1;
    vif.fifo_empty_vc1 = 1'b1;
    pend0_v = 1'b0;
    pend1_v = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);

    // Reset, then init with fixed thresholds.
    repeat (3) tick();
    reset_L = 1'b1;
    vif.init = 1'b1;
    vif.umbral_af_in = 6'd3;
    vif.umbral_ae_in = 6'd1;
    tick();
    check_eq("init_state", 32'(vif.state), 32'd1);
    tick();
    vif.init = 1'b0;
    tick();
    check_eq("idle_state", 32'(vif.state), 32'd2);
    check_eq("af_prog", 32'(vif.afVC_o), 32'd3);
    check_eq("ae_prog", 32'(vif.aeVC_o), 32'd1);

    // Single word to D1.
    w15 = 6'h15;
    q1.push_back(w15);
    saw = 1'b0;
    repeat (6) begin
      tick();
      if (vif.push_d1 && vif.data_out == w15) saw = 1'b1;
    end
    check_eq("single_push", 32'(saw), 32'd1);
    check_eq("single_idle", 32'(vif.state), 32'd2);

    // Starvation: both VCs backlogged.
    fill(15, 15);
    repeat (40) tick();

    // Pause blocks pops, release pops immediately.
    fill(3, 0);
    vif.pause_d1 = 1'b1;
    repeat (4) tick();
    vif.pause_d1 = 1'b0;
    repeat (6) tick();

    // Error with a word in flight.
    fill(4, 0);
    run_to_flight("err_flight");
    vif.fifo_error_vc1 = 1'b1;
    tick();
    vif.fifo_error_vc1 = 1'b0;
    check_eq("err_state", 32'(vif.error_out), 32'd1);
    repeat (3) tick();
    vif.init = 1'b1;
    tick();
    check_eq("err_to_init", 32'(vif.state), 32'd1);
    vif.init = 1'b0;
    repeat (3) tick();

    // Reset one cycle after a pop: word is dropped, outputs clear at once.
    fill(4, 0);
    run_to_flight("rst_flight");
    reset_L = 1'b0;
    #1;
    model_reset();
    check_eq("rst_async_state", 32'(vif.state), 32'd0);
    check_eq("rst_async_push", 32'({vif.push_d0, vif.push_d1}), 32'd0);
    check_eq("rst_async_af", 32'(vif.afVC_o), 32'd0);
    repeat (2) tick();
    reset_L = 1'b1;
    repeat (12) tick();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      vif.pause_d0 = ($urandom_range(7) == 0);
      vif.pause_d1 = ($urandom_range(7) == 0);
      vif.init = ($urandom_range(39) == 0);
      vif.fifo_error_vc0 = ($urandom_range(99) == 0);
      vif.fifo_error_vc1 = ($urandom_range(99) == 0);
      vif.umbral_af_in = DATA_SIZE'($urandom);
      vif.umbral_ae_in = DATA_SIZE'($urandom);
      if (q0.size() < 8 && $urandom_range(2) == 0) q0.push_back(DATA_SIZE'($urandom));
      if (q1.size() < 8 && $urandom_range(2) == 0) q1.push_back(DATA_SIZE'($urandom));
      tick();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
